wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file; the consumer at the far end of the MEM/WB pipeline register.
- Takes MEM/WB outputs, selects the write-back data (load data or ALU result) and commits it to a 32-entry register file.
- Serves two combinational read ports to the ID stage.
- Exports the selected write-back value and a retire counter for forwarding and debug.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- CNT_W, 32, width of the write-back retire counter

Ports:
- clk  input  1  clock; all writes on the rising edge
- reset  input  1  asynchronous, active-low reset
- regwrite_mem_wb  input  1  write enable from MEM/WB
- MemtoReg_mem_wb  input  1  1 = write load data, 0 = write ALU result
- read_data_mem_wb  input  DATA_W  load data from MEM/WB
- result_mem_wb  input  DATA_W  ALU result from MEM/WB
- Reg_dest_op_mem_wb  input  ADDR_W  destination register index
- rs_addr  input  ADDR_W  read port 1 index (ID stage)
- rt_addr  input  ADDR_W  read port 2 index (ID stage)
- rs_data  output  DATA_W  read port 1 data (combinational)
- rt_data  output  DATA_W  read port 2 data (combinational)
- wb_data  output  DATA_W  selected write-back value (combinational); feeds the EX forwarding mux
- wb_valid  output  1  high when a commit to a non-zero register occurs this cycle (combinational)
- retire_cnt  output  CNT_W  count of committed register writes (registered)

Behaviour:
- Reset (reset = 0, asynchronous): all 2**ADDR_W registers cleared to 0 and retire_cnt cleared to 0.
  - rs_data and rt_data therefore read 0 for any address.
  - wb_data and wb_valid follow their inputs even during reset.
- Reset dominates clk. A write presented in the same cycle reset deasserts is taken at the first rising edge with reset = 1.
- wb_data = MemtoReg_mem_wb ? read_data_mem_wb : result_mem_wb. This is a pure mux.
- wb_valid = regwrite_mem_wb && (Reg_dest_op_mem_wb != 0).
- Commit: on posedge clk with reset = 1 and wb_valid = 1, reg[Reg_dest_op_mem_wb] <= wb_data. The write has one-cycle latency into storage.
- Register 0 is hardwired to 0:
  - Writes to index 0 are dropped and do not count.
  - A read of index 0 always returns 0, including on bypass.
- Read ports: rs_data = reg[rs_addr] and rt_data = reg[rt_addr], combinational with no read latency. The bypass rule is defined under Optional Feature.
- Same address on both read ports: both ports return the identical value.
- retire_cnt increments by 1 on each posedge where wb_valid = 1. It wraps from 2**CNT_W-1 to 0 with no flag.
- Unknown or X regwrite_mem_wb is not supported. The bench drives only 0 or 1.
- No stall or flush input exists. Bubbles arrive as regwrite_mem_wb = 0, and the block does nothing on those cycles.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: write-through bypass. When wb_valid = 1 and rs_addr == Reg_dest_op_mem_wb (non-zero), rs_data = wb_data in the same cycle, before the clock edge. rt_data behaves identically. This removes the WB-to-ID hazard.
- Undefined: read ports return stored contents only. A same-cycle read of the register being written returns the old value; the new value is visible from the cycle after the edge. The hazard unit then owns the one-cycle stall.

Test Plan:
- Reset check: preload reg5 = 0x1234 via a commit, pulse reset low mid-cycle with no clk edge -> rs_addr = 5 reads 0x00000000 immediately and retire_cnt = 0.
- ALU write-back: regwrite = 1, MemtoReg = 0, result = 0xDEADBEEF, dest = 7, one edge, then rs_addr = 7 -> rs_data = 0xDEADBEEF and retire_cnt = 1.
- Load write-back and zero register:
  - MemtoReg = 1, read_data = 0xCAFEF00D, dest = 9 -> rt_addr = 9 reads 0xCAFEF00D.
  - Same stimulus with dest = 0 -> reg0 still reads 0, wb_valid = 0, and retire_cnt is unchanged.
- Same-cycle read/write:
  - Initial state: reg3 = 0x11, commit 0x22 to reg3, rs_addr = rt_addr = 3 during the write cycle.
  - With WB_BYPASS_EN: both ports read 0x22 before the edge.
  - Without WB_BYPASS_EN: both ports read 0x11 before the edge and 0x22 after it.
- Bubbles: regwrite = 0 with dest = 4 and result = 0xFF for 5 cycles -> reg4 is unchanged, and retire_cnt and wb_valid stay 0.
- Counter wrap: with CNT_W = 4, perform 17 commits to reg1 -> retire_cnt reads 1, and reg1 holds the last value written.

Source files
------------

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID read-port signal bundle for wb_regfile.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              regwrite_mem_wb;
    logic              MemtoReg_mem_wb;
    logic [DATA_W-1:0] read_data_mem_wb;
    logic [DATA_W-1:0] result_mem_wb;
    logic [ADDR_W-1:0] Reg_dest_op_mem_wb;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [CNT_W-1:0]  retire_cnt;

    // Pipeline / ID side drives commits and read indices
    modport master (
        output regwrite_mem_wb, MemtoReg_mem_wb, read_data_mem_wb, result_mem_wb,
               Reg_dest_op_mem_wb, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_valid, retire_cnt
    );

    // Register file side
    modport slave (
        input  regwrite_mem_wb, MemtoReg_mem_wb, read_data_mem_wb, result_mem_wb,
               Reg_dest_op_mem_wb, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_valid, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus 2**ADDR_W-entry architectural register file.
// Optional macro WB_BYPASS_EN: same-cycle write-through bypass to both read ports.
// Register 0 is hardwired to zero; retire_cnt counts commits to non-zero registers.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sel_data;
    logic              commit;

    // Write-back select and commit qualifier
    always_comb begin
        sel_data = bus.MemtoReg_mem_wb ? bus.read_data_mem_wb : bus.result_mem_wb;
        commit   = bus.regwrite_mem_wb && (bus.Reg_dest_op_mem_wb != '0);
    end

    assign bus.wb_data    = sel_data;
    assign bus.wb_valid   = commit;
    assign bus.retire_cnt = cnt;

    // Register storage; entry 0 is never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.Reg_dest_op_mem_wb] <= sel_data;
        end
    end

    // Retire counter, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (commit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Combinational read ports with zero-register masking
    always_comb begin
        bus.rs_data = (bus.rs_addr == '0) ? '0 : regs[bus.rs_addr];
        bus.rt_data = (bus.rt_addr == '0) ? '0 : regs[bus.rt_addr];
`ifdef WB_BYPASS_EN
        // commit already implies a non-zero destination
        if (commit && (bus.rs_addr == bus.Reg_dest_op_mem_wb)) begin
            bus.rs_data = sel_data;
        end
        if (commit && (bus.rt_addr == bus.Reg_dest_op_mem_wb)) begin
            bus.rt_data = sel_data;
        end
`else
        // Stored contents only; the hazard unit covers the same-cycle case
`endif
    end
endmodule
